// File: rtl/crc32_job_scheduler.sv
// FIFO-fed job scheduler around a single CRC32 calculator: issues buffered words one at a time,
// captures each result with its source word and sequence tag, and aborts jobs that never finish.
module crc32_job_scheduler #(
  parameter int FIFO_AW = 3,
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [31:0]        crc_data_in,
  output logic               crc_start,
  output logic               crc_data_valid,
  input  logic               crc_ready,
  input  logic               crc_done,
  input  logic [31:0]        crc_result,
  output logic [31:0]        res_crc,
  output logic [31:0]        res_data,
  output logic [TAG_W-1:0]   res_tag,
  output logic               res_err,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               busy,
  output logic               timeout_flag,
  input  logic               err_clr
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [FIFO_AW:0] DEPTH_L   = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] LEVEL_ONE = (FIFO_AW+1)'(1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_ONE    = WD_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t               state_r;
  logic [31:0]          mem_r [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_r;
  logic [FIFO_AW-1:0]   rd_ptr_r;
  logic [FIFO_AW:0]     level_r;
  logic [WD_W-1:0]      wd_r;
  logic [TAG_W-1:0]     tag_r;
  logic [31:0]          job_r;

  logic wr_en_s;
  logic issue_s;
  logic load_s;
  logic load_err_s;
  logic timeout_s;

  assign in_ready    = (level_r != DEPTH_L);
  assign fifo_level  = level_r;
  assign busy        = (state_r != IDLE);
  assign crc_data_in = job_r;

  // A flush discards any simultaneous write and suppresses the pop in the same cycle.
  assign wr_en_s = in_valid && in_ready && !flush;
  assign issue_s = (state_r == IDLE) && !flush && (level_r != {(FIFO_AW+1){1'b0}}) &&
                   crc_ready && (!res_valid || res_ready);

  // Decide whether the result slot is loaded this cycle, and with what kind of result.
  always_comb begin
    load_s     = 1'b0;
    load_err_s = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      ISSUE: begin
        if (flush) begin
          load_s     = 1'b1;
          load_err_s = 1'b1;
        end else begin
          load_s     = 1'b0;
        end
      end
      WAIT: begin
        if (flush) begin
          load_s     = 1'b1;
          load_err_s = 1'b1;
        end else if (crc_done) begin
          load_s     = 1'b1;
        end else if (wd_r == WD_LAST) begin
          load_s     = 1'b1;
          load_err_s = 1'b1;
          timeout_s  = 1'b1;
        end else begin
          load_s     = 1'b0;
        end
      end
      default: begin
        load_s     = 1'b0;
      end
    endcase
  end

  // FIFO storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {FIFO_AW{1'b0}};
      rd_ptr_r <= {FIFO_AW{1'b0}};
      level_r  <= {(FIFO_AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {FIFO_AW{1'b0}};
      rd_ptr_r <= {FIFO_AW{1'b0}};
      level_r  <= {(FIFO_AW+1){1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
      if (issue_s) rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
      case ({wr_en_s, issue_s})
        2'b10:   level_r <= level_r + LEVEL_ONE;
        2'b01:   level_r <= level_r - LEVEL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Job sequencing: pop into the job register, one-cycle start strobe, then watchdog-guarded wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      wd_r           <= {WD_W{1'b0}};
      job_r          <= 32'h0000_0000;
      crc_start      <= 1'b0;
      crc_data_valid <= 1'b0;
    end else begin
      crc_start      <= 1'b0;
      crc_data_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            state_r        <= ISSUE;
            job_r          <= mem_r[rd_ptr_r];
            crc_start      <= 1'b1;
            crc_data_valid <= 1'b1;
          end
        end
        ISSUE: begin
          wd_r    <= {WD_W{1'b0}};
          state_r <= flush ? IDLE : WAIT;
        end
        WAIT: begin
          if (load_s) state_r <= IDLE;
          else        wd_r    <= wd_r + WD_ONE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Result slot and sequence tag; a load in the same cycle as a consume keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_crc   <= 32'h0000_0000;
      res_data  <= 32'h0000_0000;
      res_tag   <= {TAG_W{1'b0}};
      res_err   <= 1'b0;
      tag_r     <= {TAG_W{1'b0}};
    end else if (load_s) begin
      res_valid <= 1'b1;
      res_crc   <= load_err_s ? 32'h0000_0000 : crc_result;
      res_data  <= job_r;
      res_tag   <= tag_r;
      res_err   <= load_err_s;
      tag_r     <= tag_r + TAG_W'(1);
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Sticky timeout indication; a new timeout outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_flag <= 1'b0;
    end else if (timeout_s) begin
      timeout_flag <= 1'b1;
    end else if (err_clr) begin
      timeout_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crc32_job_scheduler.sv
// Self-checking bench for crc32_job_scheduler with a behavioural CRC32 calculator stub and
// a result-queue reference model built from the job-ordering and tagging rules.
module tb_crc32_job_scheduler;

  localparam int FIFO_AW  = 3;
  localparam int TIMEOUT  = 64;
  localparam int TAG_W    = 8;
  localparam int DEPTH    = 8;
  localparam int CALC_LAT = 38;

  typedef struct packed {
    logic [31:0]      crc;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [31:0]      crc_data_in;
  logic             crc_start;
  logic             crc_data_valid;
  logic             crc_ready;
  logic             crc_done;
  logic [31:0]      crc_result;
  logic [31:0]      res_crc;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;
  logic             res_valid;
  logic             res_ready;
  logic [FIFO_AW:0] fifo_level;
  logic             busy;
  logic             timeout_flag;
  logic             err_clr;

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t got_q[$];
  res_t exp_q[$];
  int   model_tag;
  int   peak_level;
  bit   full_seen;
  int   start_cnt;
  bit   calc_hang;
  int   calc_cnt;
  logic [31:0] calc_word;

  crc32_job_scheduler #(.FIFO_AW(FIFO_AW), .TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .crc_data_in(crc_data_in), .crc_start(crc_start),
    .crc_data_valid(crc_data_valid), .crc_ready(crc_ready), .crc_done(crc_done),
    .crc_result(crc_result), .res_crc(res_crc), .res_data(res_data), .res_tag(res_tag),
    .res_err(res_err), .res_valid(res_valid), .res_ready(res_ready), .fifo_level(fifo_level),
    .busy(busy), .timeout_flag(timeout_flag), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Standard reflected CRC-32 over the four bytes of a word, least significant byte first.
  function automatic logic [31:0] crc32_ref(input logic [31:0] w);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int b = 0; b < 4; b++) begin
      c = c ^ {24'h00_0000, w[8*b +: 8]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Calculator stub: ready while idle, pulses done CALC_LAT edges after start; hangs when asked.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_ready  <= 1'b1;
      crc_done   <= 1'b0;
      crc_result <= 32'h0;
      calc_cnt   <= 0;
      calc_word  <= 32'h0;
    end else begin
      crc_done <= 1'b0;
      if (calc_cnt != 0) begin
        calc_cnt <= calc_cnt - 1;
        if (calc_cnt == 1) begin
          crc_done   <= 1'b1;
          crc_result <= crc32_ref(calc_word);
          crc_ready  <= 1'b1;
        end
      end else if (crc_start && !calc_hang) begin
        calc_word <= crc_data_in;
        calc_cnt  <= CALC_LAT;
        crc_ready <= 1'b0;
      end
    end
  end

  // Output monitor: records delivered results and FIFO/issue observations.
  always @(negedge clk) begin
    if (!rst_n) begin
      got_q.delete();
      peak_level = 0;
      full_seen  = 1'b0;
      start_cnt  = 0;
    end else begin
      if (res_valid && res_ready) got_q.push_back(res_t'({res_crc, res_data, res_tag, res_err}));
      if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
      if (fifo_level == 4'(DEPTH) && !in_ready) full_seen = 1'b1;
      if (crc_start) start_cnt++;
    end
  end

  task automatic do_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; flush = 1'b0; err_clr = 1'b0;
    res_ready = 1'b1; calc_hang = 1'b0;
    exp_q.delete();
    model_tag = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic add_exp(input logic [31:0] w, input logic err);
    res_t r;
    r.crc  = err ? 32'h0 : crc32_ref(w);
    r.data = w;
    r.tag  = TAG_W'(model_tag);
    r.err  = err;
    exp_q.push_back(r);
    model_tag++;
  endtask

  task automatic push_word(input logic [31:0] w, output bit ok);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    ok = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (got_q.size() >= n);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({in_ready, fifo_level, busy, timeout_flag} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_status: got in_ready=%b level=%0d busy=%b tflag=%b, expected 1 0 0 0",
               in_ready, fifo_level, busy, timeout_flag);
    end
    n_cmp++;
    if ({crc_start, crc_data_valid, crc_data_in} !== {1'b0, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_crc_port: got start=%b dv=%b data=%h, expected 0 0 0",
               crc_start, crc_data_valid, crc_data_in);
    end
    n_cmp++;
    if ({res_valid, res_crc, res_data, res_tag, res_err} !== {1'b0, 32'h0, 32'h0, 8'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_result: got valid=%b crc=%h data=%h tag=%0d err=%b, expected all 0",
               res_valid, res_crc, res_data, res_tag, res_err);
    end
  endtask

  task automatic test_single;
    bit ok;
    do_reset();
    push_word(32'h3433_3231, ok);
    add_exp(32'h3433_3231, 1'b0);
    wait_results(1, 300, ok);
    n_cmp++;
    if (!ok || got_q.size() != 1) begin
      n_bad++;
      $display("FAIL single_count: got %0d results, expected 1", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0] !== exp_q[0] || got_q[0].crc !== 32'h9BE3_E0A3) begin
        n_bad++;
        $display("FAIL single_res: got crc=%h data=%h tag=%0d err=%b, expected crc=9be3e0a3 data=%h tag=%0d err=%b",
                 got_q[0].crc, got_q[0].data, got_q[0].tag, got_q[0].err,
                 exp_q[0].data, exp_q[0].tag, exp_q[0].err);
      end
    end
  endtask

  task automatic test_burst;
    bit ok, all_ok;
    logic [31:0] w;
    do_reset();
    all_ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      w = (i == 4) ? 32'h0 : $urandom;
      push_word(w, ok);
      all_ok = all_ok & ok;
      add_exp(w, 1'b0);
    end
    n_cmp++;
    if (!all_ok) begin
      n_bad++;
      $display("FAIL burst_accept: some word never accepted, expected all 9 accepted");
    end
    wait_results(9, 2000, ok);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL burst_count: got %0d results, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL burst_res[%0d]: got crc=%h data=%h tag=%0d err=%b, expected crc=%h data=%h tag=%0d err=%b",
                 i, got_q[i].crc, got_q[i].data, got_q[i].tag, got_q[i].err,
                 exp_q[i].crc, exp_q[i].data, exp_q[i].tag, exp_q[i].err);
      end
    end
    if (got_q.size() > 4) begin
      n_cmp++;
      if (got_q[4].crc !== 32'h2144_DF1C) begin
        n_bad++;
        $display("FAIL burst_zero_crc: got %h, expected 2144df1c", got_q[4].crc);
      end
    end
    n_cmp++;
    if (peak_level != DEPTH || !full_seen) begin
      n_bad++;
      $display("FAIL burst_full: got peak=%0d full_blocked=%b, expected peak=%0d full_blocked=1",
               peak_level, full_seen, DEPTH);
    end
  endtask

  task automatic test_backpressure;
    bit ok, stable;
    int k, s0;
    logic [31:0] snap_data;
    logic [TAG_W-1:0] snap_tag;
    logic [31:0] w0, w1;
    do_reset();
    res_ready = 1'b0;
    w0 = $urandom;
    w1 = $urandom;
    push_word(w0, ok); add_exp(w0, 1'b0);
    push_word(w1, ok); add_exp(w1, 1'b0);
    k = 0;
    @(negedge clk);
    while (!res_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!res_valid) begin
      n_bad++;
      $display("FAIL bp_first: got res_valid=0 after %0d cycles, expected 1", k);
    end
    snap_data = res_data;
    snap_tag  = res_tag;
    s0 = start_cnt;
    stable = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (!res_valid || res_data !== snap_data || res_tag !== snap_tag) stable = 1'b0;
    end
    n_cmp++;
    if (!stable || snap_data !== w0) begin
      n_bad++;
      $display("FAIL bp_hold: got stable=%b data=%h, expected stable=1 data=%h", stable, snap_data, w0);
    end
    n_cmp++;
    if (start_cnt != s0) begin
      n_bad++;
      $display("FAIL bp_no_issue: got %0d starts while stalled, expected 0", start_cnt - s0);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_results(2, 400, ok);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL bp_count: got %0d results, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL bp_res[%0d]: got crc=%h data=%h tag=%0d err=%b, expected crc=%h data=%h tag=%0d err=%b",
                 i, got_q[i].crc, got_q[i].data, got_q[i].tag, got_q[i].err,
                 exp_q[i].crc, exp_q[i].data, exp_q[i].tag, exp_q[i].err);
      end
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int k, cyc;
    logic [31:0] w;
    do_reset();
    calc_hang = 1'b1;
    w = $urandom;
    push_word(w, ok);
    add_exp(w, 1'b1);
    k = 0;
    @(negedge clk);
    while (!crc_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    cyc = 0;
    @(negedge clk);
    while (!res_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc != TIMEOUT || !res_err || res_crc !== 32'h0 || !timeout_flag) begin
      n_bad++;
      $display("FAIL timeout_result: got %0d cycles err=%b crc=%h tflag=%b, expected %0d cycles err=1 crc=0 tflag=1",
               cyc, res_err, res_crc, timeout_flag, TIMEOUT);
    end
    wait_results(1, 50, ok);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_bad++;
      $display("FAIL timeout_record: got %0d results, expected 1 with tag 0 err=1 data=%h", got_q.size(), w);
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (timeout_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_sticky: got tflag=%b, expected 1", timeout_flag);
    end
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (timeout_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_clear: got tflag=%b, expected 0", timeout_flag);
    end
  endtask

  task automatic test_flush;
    bit ok;
    int k;
    logic [31:0] w0, w3;
    do_reset();
    w0 = $urandom;
    w3 = $urandom;
    push_word(w0, ok); add_exp(w0, 1'b1);
    push_word($urandom, ok);
    push_word($urandom, ok);
    k = 0;
    @(negedge clk);
    while (!busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (fifo_level !== 4'd2 || !busy) begin
      n_bad++;
      $display("FAIL flush_pre: got level=%0d busy=%b, expected level=2 busy=1", fifo_level, busy);
    end
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fifo_level !== 4'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_post: got level=%0d busy=%b, expected level=0 busy=0", fifo_level, busy);
    end
    wait_results(1, 50, ok);
    repeat (60) @(negedge clk);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_bad++;
      $display("FAIL flush_late_done: got %0d results, expected 1", got_q.size());
    end
    @(posedge clk);
    #1;
    push_word(w3, ok);
    add_exp(w3, 1'b0);
    wait_results(2, 300, ok);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL flush_count: got %0d results, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL flush_res[%0d]: got crc=%h data=%h tag=%0d err=%b, expected crc=%h data=%h tag=%0d err=%b",
                 i, got_q[i].crc, got_q[i].data, got_q[i].tag, got_q[i].err,
                 exp_q[i].crc, exp_q[i].data, exp_q[i].tag, exp_q[i].err);
      end
    end
  endtask

  task automatic test_random;
    bit ok;
    int k, pushed;
    do_reset();
    k = 0;
    pushed = 0;
    while (pushed < 12 && k < 3000) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      res_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        add_exp(in_data, 1'b0);
        pushed++;
      end
      k++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    res_ready = 1'b1;
    wait_results(pushed, 1500, ok);
    n_cmp++;
    if (got_q.size() != exp_q.size() || pushed != 12) begin
      n_bad++;
      $display("FAIL random_count: got %0d results for %0d words, expected %0d for 12",
               got_q.size(), pushed, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL random_res[%0d]: got crc=%h data=%h tag=%0d err=%b, expected crc=%h data=%h tag=%0d err=%b",
                 i, got_q[i].crc, got_q[i].data, got_q[i].tag, got_q[i].err,
                 exp_q[i].crc, exp_q[i].data, exp_q[i].tag, exp_q[i].err);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int k;
    do_reset();
    push_word($urandom, ok);
    push_word($urandom, ok);
    k = 0;
    @(negedge clk);
    while (!busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({busy, res_valid, fifo_level, in_ready, crc_start} !== {1'b0, 1'b0, 4'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: got busy=%b valid=%b level=%0d in_ready=%b start=%b, expected 0 0 0 1 0",
               busy, res_valid, fifo_level, in_ready, crc_start);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_timeout();
    test_flush();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
